// File: rtl/bus_str_serializer.sv
// Bus-to-stream serializer: buffers {adr,dat} bus writes in a small FIFO and emits each
// as an LSB-first byte frame (address then data, or data only) with a last-byte marker.
module bus_str_serializer #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int SW         = 8,
  parameter int HDR        = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bsi_vld,
  input  logic [AW-1:0] bsi_adr,
  input  logic [DW-1:0] bsi_dat,
  output logic          bsi_rdy,
  output logic          str_vld,
  output logic [SW-1:0] str_bus,
  output logic          str_lst,
  input  logic          str_rdy,
  output logic [15:0]   cnt_frm
);

  localparam int ABYTES = AW / 8;
  localparam int DBYTES = DW / 8;
  localparam int FW     = AW + DW;
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CW     = 8;

  localparam logic [PW:0]   PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;
  localparam logic [CW-1:0] ALAST   = CW'(ABYTES - 1);
  localparam logic [CW-1:0] DLAST   = CW'(DBYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADR, S_DAT} state_t;

  localparam state_t S_FIRST = (HDR != 0) ? S_ADR : S_DAT;

  logic [FW-1:0]   r_mem [FIFO_DEPTH];
  logic [PW:0]     r_wptr;
  logic [PW:0]     r_rptr;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [FW-1:0]   w_head;
  logic [FW-1:0]   w_frame;

  state_t          r_state;
  state_t          w_nxt_state;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_nxt_cnt;
  logic            w_load;
  logic            w_shift;
  logic            w_frm_done;
  logic [FW-1:0]   r_shift;
  logic            r_lst;
  logic [15:0]     r_cnt_frm;

  // FIFO bookkeeping: extra pointer MSB distinguishes full from empty
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign bsi_rdy = rst & ~w_full;
  assign w_push  = bsi_vld & bsi_rdy;
  assign w_head  = r_mem[r_rptr[PW-1:0]];

  // Address goes in the low bytes so it leaves first when a header is sent
  assign w_frame = (HDR != 0) ? {w_head[DW-1:0], w_head[FW-1:DW]} : w_head;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[PW-1:0]] <= {bsi_adr, bsi_dat};
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_frm_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_load      = 1'b1;
          w_nxt_cnt   = '0;
          w_nxt_state = S_FIRST;
        end
      end
      S_ADR: begin
        if (str_rdy) begin
          w_shift = 1'b1;
          if (r_cnt == ALAST) begin
            w_nxt_state = S_DAT;
            w_nxt_cnt   = '0;
          end else begin
            w_nxt_cnt = r_cnt + CNT_ONE;
          end
        end
      end
      S_DAT: begin
        if (str_rdy) begin
          if (r_cnt == DLAST) begin
            w_frm_done = 1'b1;
            w_nxt_cnt  = '0;
            // Chain straight into the next frame so there is no idle cycle
            if (!w_empty) begin
              w_pop       = 1'b1;
              w_load      = 1'b1;
              w_nxt_state = S_FIRST;
            end else begin
              w_nxt_state = S_IDLE;
            end
          end else begin
            w_shift   = 1'b1;
            w_nxt_cnt = r_cnt + CNT_ONE;
          end
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_lst     <= 1'b0;
      r_shift   <= '0;
      r_cnt_frm <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_lst   <= (w_nxt_state == S_DAT) && (w_nxt_cnt == DLAST);
      if (w_load)       r_shift <= w_frame;
      else if (w_shift) r_shift <= r_shift >> SW;
      if (w_frm_done)   r_cnt_frm <= r_cnt_frm + 16'd1;
    end
  end

  assign str_vld = (r_state != S_IDLE);
  assign str_bus = r_shift[SW-1:0];
  assign str_lst = r_lst;
  assign cnt_frm = r_cnt_frm;

endmodule

// File: tb/tb_bus_str_serializer.sv
// Directed and randomized bench for bus_str_serializer: header and data-only instances,
// checking frame bytes, last markers, stalls, capacity, mid-frame reset and frame count.
module tb_bus_str_serializer;

  logic        clk;
  logic        rst;
  logic        bsi_vld;
  logic [31:0] bsi_adr;
  logic [31:0] bsi_dat;
  logic        bsi_rdy;
  logic        str_vld;
  logic [7:0]  str_bus;
  logic        str_lst;
  logic        str_rdy;
  logic [15:0] cnt_frm;

  logic        h0_bsi_vld;
  logic [31:0] h0_bsi_adr;
  logic [31:0] h0_bsi_dat;
  logic        h0_bsi_rdy;
  logic        h0_str_vld;
  logic [7:0]  h0_str_bus;
  logic        h0_str_lst;
  logic        h0_str_rdy;
  logic [15:0] h0_cnt_frm;

  int checks = 0;
  int errors = 0;

  bus_str_serializer u_dut (
    .clk(clk), .rst(rst),
    .bsi_vld(bsi_vld), .bsi_adr(bsi_adr), .bsi_dat(bsi_dat), .bsi_rdy(bsi_rdy),
    .str_vld(str_vld), .str_bus(str_bus), .str_lst(str_lst), .str_rdy(str_rdy),
    .cnt_frm(cnt_frm)
  );

  bus_str_serializer #(.HDR(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .bsi_vld(h0_bsi_vld), .bsi_adr(h0_bsi_adr), .bsi_dat(h0_bsi_dat), .bsi_rdy(h0_bsi_rdy),
    .str_vld(h0_str_vld), .str_bus(h0_str_bus), .str_lst(h0_str_lst), .str_rdy(h0_str_rdy),
    .cnt_frm(h0_cnt_frm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected byte idx (0..7) of a header frame: address bytes LSB first, then data bytes
  function automatic logic [7:0] tb_byte(input logic [31:0] a, input logic [31:0] d, input int idx);
    logic [31:0] w;
    w = (idx < 4) ? a : d;
    return 8'((w >> (8 * (idx % 4))) & 32'hFF);
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    bsi_vld = 1'b0; bsi_adr = '0; bsi_dat = '0; str_rdy = 1'b1;
    h0_bsi_vld = 1'b0; h0_bsi_adr = '0; h0_bsi_dat = '0; h0_str_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bsi_vld = 1'b1; bsi_adr = 32'h1; bsi_dat = 32'h2; str_rdy = 1'b1;
    h0_bsi_vld = 1'b0; h0_bsi_adr = '0; h0_bsi_dat = '0; h0_str_rdy = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (str_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", str_vld); end
    checks++; if (str_lst !== 1'b0) begin errors++; $display("FAIL reset_lst: got %b want 0", str_lst); end
    checks++; if (str_bus !== 8'h00) begin errors++; $display("FAIL reset_bus: got %h want 00", str_bus); end
    checks++; if (cnt_frm !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0000", cnt_frm); end
    checks++; if (bsi_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", bsi_rdy); end
    bsi_vld = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checks++; if (bsi_rdy !== 1'b1) begin errors++; $display("FAIL release_rdy: got %b want 1", bsi_rdy); end
    checks++; if (str_vld !== 1'b0) begin errors++; $display("FAIL release_vld: got %b want 0", str_vld); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [7:0] exp [8];
    exp = '{8'h10, 8'h00, 8'h00, 8'h00, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
    do_reset();
    bsi_vld = 1'b1; bsi_adr = 32'h10; bsi_dat = 32'hA1B2C3D4; str_rdy = 1'b1;
    @(negedge clk);
    checks++; if (bsi_rdy !== 1'b1) begin errors++; $display("FAIL single_rdy: got %b want 1", bsi_rdy); end
    @(posedge clk); #1 bsi_vld = 1'b0;
    @(negedge clk);
    checks++; if (str_vld !== 1'b0) begin errors++; $display("FAIL single_latency: got vld %b want 0", str_vld); end
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (str_vld !== 1'b1 || str_bus !== exp[i] || str_lst !== (i == 7)) begin
        errors++;
        $display("FAIL single_byte%0d: got vld=%b bus=%h lst=%b want vld=1 bus=%h lst=%b",
                 i, str_vld, str_bus, str_lst, exp[i], (i == 7));
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (str_vld !== 1'b0) begin errors++; $display("FAIL single_end_vld: got %b want 0", str_vld); end
    checks++; if (cnt_frm !== 16'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", cnt_frm); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int w, got, gaps;
    bit started, pushed;
    logic [7:0] eb;
    logic el;
    do_reset();
    w = 0; got = 0; gaps = 0; started = 1'b0;
    bsi_vld = 1'b1; bsi_adr = 32'h100; bsi_dat = 32'hC0DE0000; str_rdy = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 32; cyc++) begin
      @(negedge clk);
      pushed = bsi_vld && bsi_rdy;
      if (str_vld) begin
        started = 1'b1;
        eb = tb_byte(32'h100 + 32'(got / 8), 32'hC0DE0000 + 32'(got / 8) * 32'h1111, got % 8);
        el = (got % 8 == 7);
        checks++;
        if (str_bus !== eb || str_lst !== el) begin
          errors++;
          $display("FAIL b2b_byte%0d: got bus=%h lst=%b want bus=%h lst=%b", got, str_bus, str_lst, eb, el);
        end
        got++;
      end else if (started) begin
        gaps++;
      end
      @(posedge clk); #1;
      if (pushed) w++;
      bsi_vld = (w < 4);
      bsi_adr = 32'h100 + 32'(w);
      bsi_dat = 32'hC0DE0000 + 32'(w) * 32'h1111;
    end
    checks++; if (got !== 32) begin errors++; $display("FAIL b2b_count: got %0d bytes want 32", got); end
    checks++; if (gaps !== 0) begin errors++; $display("FAIL b2b_gaps: got %0d idle cycles want 0", gaps); end
    @(negedge clk);
    checks++; if (str_vld !== 1'b0) begin errors++; $display("FAIL b2b_end_vld: got %b want 0", str_vld); end
    checks++; if (cnt_frm !== 16'd4) begin errors++; $display("FAIL b2b_cnt: got %0d want 4", cnt_frm); end
    @(posedge clk); #1;
  endtask

  task automatic test_stall_capacity();
    int w, acc, unstable, got;
    bit pushed, held, rdy_chk;
    logic [7:0] hb, eb;
    logic el;
    do_reset();
    w = 0; acc = 0; unstable = 0; held = 1'b0; hb = '0;
    str_rdy = 1'b0; bsi_vld = 1'b1; bsi_adr = 32'hA0; bsi_dat = 32'h30000000;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      pushed = bsi_vld && bsi_rdy;
      if (pushed) acc++;
      if (str_vld) begin
        if (!held) begin held = 1'b1; hb = str_bus; end
        else if (str_bus !== hb || str_lst !== 1'b0) unstable++;
      end
      @(posedge clk); #1;
      if (pushed) w++;
      bsi_adr = 32'hA0 + 32'(w);
      bsi_dat = 32'h30000000 + 32'(w);
    end
    @(negedge clk);
    checks++; if (acc !== 3) begin errors++; $display("FAIL stall_accepted: got %0d want 3", acc); end
    checks++; if (bsi_rdy !== 1'b0) begin errors++; $display("FAIL stall_rdy: got %b want 0", bsi_rdy); end
    checks++; if (str_vld !== 1'b1) begin errors++; $display("FAIL stall_vld: got %b want 1", str_vld); end
    checks++; if (hb !== 8'hA0) begin errors++; $display("FAIL stall_first_byte: got %h want a0", hb); end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL stall_stable: got %0d changes want 0", unstable); end
    @(posedge clk); #1;
    bsi_vld = 1'b0; str_rdy = 1'b1;
    got = 0; rdy_chk = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 24; cyc++) begin
      @(negedge clk);
      if (got == 8 && !rdy_chk) begin
        rdy_chk = 1'b1;
        checks++; if (bsi_rdy !== 1'b1) begin errors++; $display("FAIL stall_rdy_reassert: got %b want 1", bsi_rdy); end
      end
      if (str_vld) begin
        if (got == 7) begin
          checks++; if (bsi_rdy !== 1'b0) begin errors++; $display("FAIL stall_rdy_before_pop: got %b want 0", bsi_rdy); end
        end
        eb = tb_byte(32'hA0 + 32'(got / 8), 32'h30000000 + 32'(got / 8), got % 8);
        el = (got % 8 == 7);
        checks++;
        if (str_bus !== eb || str_lst !== el) begin
          errors++;
          $display("FAIL stall_byte%0d: got bus=%h lst=%b want bus=%h lst=%b", got, str_bus, str_lst, eb, el);
        end
        got++;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (got !== 24) begin errors++; $display("FAIL stall_drain_count: got %0d want 24", got); end
    checks++; if (cnt_frm !== 16'd3) begin errors++; $display("FAIL stall_cnt: got %0d want 3", cnt_frm); end
    @(posedge clk); #1;
  endtask

  task automatic test_no_header();
    logic [7:0] exp [4];
    exp = '{8'h04, 8'h03, 8'h02, 8'h01};
    h0_bsi_vld = 1'b1; h0_bsi_adr = 32'hDEADBEEF; h0_bsi_dat = 32'h01020304; h0_str_rdy = 1'b1;
    @(posedge clk); #1 h0_bsi_vld = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (h0_str_vld !== 1'b1 || h0_str_bus !== exp[i] || h0_str_lst !== (i == 3)) begin
        errors++;
        $display("FAIL nohdr_byte%0d: got vld=%b bus=%h lst=%b want vld=1 bus=%h lst=%b",
                 i, h0_str_vld, h0_str_bus, h0_str_lst, exp[i], (i == 3));
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (h0_str_vld !== 1'b0) begin errors++; $display("FAIL nohdr_end_vld: got %b want 0", h0_str_vld); end
    checks++; if (h0_cnt_frm !== 16'd1) begin errors++; $display("FAIL nohdr_cnt: got %0d want 1", h0_cnt_frm); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] eb;
    int stray;
    str_rdy = 1'b1; bsi_vld = 1'b1; bsi_adr = 32'h55667788; bsi_dat = 32'h11223344;
    @(negedge clk);
    checks++; if (cnt_frm !== 16'd3) begin errors++; $display("FAIL mid_pre_cnt: got %0d want 3", cnt_frm); end
    @(posedge clk); #1 bsi_adr = 32'h99AABBCC; bsi_dat = 32'hDDEEFF00;
    @(posedge clk); #1 bsi_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      eb = tb_byte(32'h55667788, 32'h11223344, i);
      checks++;
      if (str_vld !== 1'b1 || str_bus !== eb) begin
        errors++;
        $display("FAIL mid_byte%0d: got vld=%b bus=%h want vld=1 bus=%h", i, str_vld, str_bus, eb);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bsi_rdy !== 1'b0) begin errors++; $display("FAIL mid_rdy_low: got %b want 0", bsi_rdy); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (str_vld !== 1'b0) begin errors++; $display("FAIL mid_vld: got %b want 0", str_vld); end
    checks++; if (cnt_frm !== 16'd0) begin errors++; $display("FAIL mid_cnt: got %0d want 0", cnt_frm); end
    checks++; if (str_bus !== 8'h00 || str_lst !== 1'b0) begin
      errors++; $display("FAIL mid_bus: got bus=%h lst=%b want bus=00 lst=0", str_bus, str_lst);
    end
    @(posedge clk); #1 rst = 1'b1;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (str_vld !== 1'b0) stray++;
      @(posedge clk); #1;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL mid_fifo_flushed: got %0d valid cycles want 0", stray); end
    bsi_vld = 1'b1; bsi_adr = 32'hCAFE0001; bsi_dat = 32'h0BADF00D;
    @(posedge clk); #1 bsi_vld = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      eb = tb_byte(32'hCAFE0001, 32'h0BADF00D, i);
      checks++;
      if (str_vld !== 1'b1 || str_bus !== eb || str_lst !== (i == 7)) begin
        errors++;
        $display("FAIL mid_new_byte%0d: got vld=%b bus=%h lst=%b want vld=1 bus=%h lst=%b",
                 i, str_vld, str_bus, str_lst, eb, (i == 7));
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (cnt_frm !== 16'd1) begin errors++; $display("FAIL mid_new_cnt: got %0d want 1", cnt_frm); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [7:0] q [$];
    logic [7:0] eb, pb;
    logic pl, el;
    int w, got;
    bit pstall, done;
    do_reset();
    w = 0; got = 0; pstall = 1'b0; pb = '0; pl = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 30000 && !done; cyc++) begin
      bsi_vld = (w < 256) && ($urandom_range(0, 1) == 1);
      bsi_adr = $urandom;
      bsi_dat = $urandom;
      str_rdy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (pstall) begin
        checks++;
        if (str_vld !== 1'b1 || str_bus !== pb || str_lst !== pl) begin
          errors++;
          $display("FAIL rand_stall_hold: got vld=%b bus=%h lst=%b want vld=1 bus=%h lst=%b",
                   str_vld, str_bus, str_lst, pb, pl);
        end
      end
      if (bsi_vld && bsi_rdy) begin
        for (int j = 0; j < 8; j++) q.push_back(tb_byte(bsi_adr, bsi_dat, j));
        w++;
      end
      if (str_vld && str_rdy) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra_byte: got bus=%h want no byte", str_bus);
        end else begin
          eb = q.pop_front();
          el = (got % 8 == 7);
          if (str_bus !== eb || str_lst !== el) begin
            errors++;
            $display("FAIL rand_byte%0d: got bus=%h lst=%b want bus=%h lst=%b", got, str_bus, str_lst, eb, el);
          end
        end
        got++;
      end
      pstall = str_vld && !str_rdy;
      pb = str_bus;
      pl = str_lst;
      done = (w == 256) && (got == 2048);
      @(posedge clk); #1;
    end
    bsi_vld = 1'b0; str_rdy = 1'b1;
    checks++; if (!done) begin errors++; $display("FAIL rand_timeout: got %0d writes %0d bytes want 256 writes 2048 bytes", w, got); end
    @(negedge clk);
    checks++; if (cnt_frm !== 16'h0100) begin errors++; $display("FAIL rand_cnt: got %h want 0100", cnt_frm); end
    checks++; if (str_vld !== 1'b0) begin errors++; $display("FAIL rand_end_vld: got %b want 0", str_vld); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    bsi_vld = 1'b0; bsi_adr = '0; bsi_dat = '0; str_rdy = 1'b1;
    h0_bsi_vld = 1'b0; h0_bsi_adr = '0; h0_bsi_dat = '0; h0_str_rdy = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall_capacity();
    test_no_header();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
